// File: rtl/ecc_error_collector.sv
// ecc_error_collector
//
// Turns per-bank ECC status levels into single-cycle error events. Each
// rising edge on a bank's status line is held as a pending request. The
// lowest-numbered pending bank is moved into a small record FIFO, at most
// one per cycle. Every accepted record produces a one-cycle eccStatus pulse,
// which feeds the cosmic-ray detector. The host reads the records back through
// a show-ahead valid/ready port.
//
// Build option:
//   ECC_ERROR_TIMESTAMP_EN  When defined, a free-running 32-bit cycle counter
//                           is kept and each record stores its capture time.
//                           When undefined, there is no counter and no time
//                           storage, and eventTime is tied to zero.
//
// Parameters:
//   NUM_SOURCES  number of bank status inputs (2..64)
//   FIFO_DEPTH   record FIFO depth (power of two, >= 2)
//   COUNT_WIDTH  width of the saturating event counters
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   eccStatusIn   level ECC status per bank, synchronous to clk
//   eccStatus     one-cycle pulse per record accepted into the FIFO
//   eventValid    FIFO holds at least one record
//   eventReady    consumer pops the head when eventValid && eventReady
//   eventSource   bank index of the head record (zero-extended to 6 bits)
//   eventTime     capture timestamp of the head record (0 without timestamps)
//   eventCount    records accepted into the FIFO, saturating
//   droppedCount  edges merged into an already-pending request, saturating

module ecc_error_collector #(
  parameter int NUM_SOURCES = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SOURCES-1:0] eccStatusIn,
  output logic                   eccStatus,
  output logic                   eventValid,
  input  logic                   eventReady,
  output logic [5:0]             eventSource,
  output logic [31:0]            eventTime,
  output logic [COUNT_WIDTH-1:0] eventCount,
  output logic [COUNT_WIDTH-1:0] droppedCount
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int POP_W = $clog2(NUM_SOURCES + 1);
  // Wide enough that a full counter plus a full-width popcount never overflows.
  localparam int SUM_W = COUNT_WIDTH + POP_W;

  // ------------------------------------------------------------------
  // Input capture and edge detection
  // ------------------------------------------------------------------
  logic [NUM_SOURCES-1:0] in_reg;
  logic [NUM_SOURCES-1:0] in_prev_reg;
  logic [NUM_SOURCES-1:0] rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_reg      <= '0;
      in_prev_reg <= '0;
    end else begin
      in_reg      <= eccStatusIn;
      in_prev_reg <= in_reg;
    end
  end

  assign rise = in_reg & ~in_prev_reg;

  // ------------------------------------------------------------------
  // Pending requests and lowest-index selection
  // ------------------------------------------------------------------
  logic [NUM_SOURCES-1:0] pending_reg;
  logic [NUM_SOURCES-1:0] pending_next;
  logic [NUM_SOURCES-1:0] clear_mask;
  logic [NUM_SOURCES-1:0] merged;
  logic [5:0]             sel_idx;
  logic                   sel_valid;
  logic [POP_W-1:0]       merged_count;
  logic                   push;
  logic                   pop;

  // Scanning from the top down leaves the lowest set index in sel_idx.
  always_comb begin
    sel_idx   = '0;
    sel_valid = 1'b0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (pending_reg[i]) begin
        sel_idx   = 6'(i);
        sel_valid = 1'b1;
      end
    end
  end

  // A rise on the bit being cleared re-arms it as a fresh event, so it is
  // not a merge. Only rises onto a pending bit that stays pending are merged.
  generate
    for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_pending
      assign clear_mask[gi]   = push && (sel_idx == 6'(gi));
      assign merged[gi]       = rise[gi] && pending_reg[gi] && !clear_mask[gi];
      assign pending_next[gi] = (pending_reg[gi] && !clear_mask[gi]) || rise[gi];
    end
  endgenerate

  always_comb begin
    merged_count = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      merged_count = merged_count + {{(POP_W - 1){1'b0}}, merged[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  // ------------------------------------------------------------------
  // Record FIFO (show-ahead, register storage)
  // ------------------------------------------------------------------
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [OCC_W-1:0] occ_reg;
  logic             fifo_empty;
  logic             fifo_full;
  logic [5:0]       src_mem [FIFO_DEPTH];

  assign fifo_empty = (occ_reg == '0);
  assign fifo_full  = (occ_reg == OCC_W'(FIFO_DEPTH));
  assign pop        = !fifo_empty && eventReady;
  // A pop frees the head slot at the same edge, so a full FIFO still accepts
  // a push when it is being drained.
  assign push       = sel_valid && (!fifo_full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + OCC_W'(1);
        2'b01:   occ_reg <= occ_reg - OCC_W'(1);
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        src_mem[i] <= '0;
      end
    end else if (push) begin
      src_mem[wr_ptr_reg] <= sel_idx;
    end
  end

  assign eventValid  = !fifo_empty;
  assign eventSource = src_mem[rd_ptr_reg];

`ifdef ECC_ERROR_TIMESTAMP_EN
  // ------------------------------------------------------------------
  // Timestamp: counts clock edges since reset. A record stores the value
  // the counter takes at its push edge.
  // ------------------------------------------------------------------
  logic [31:0] ts_reg;
  logic [31:0] ts_next;
  logic [31:0] time_mem [FIFO_DEPTH];

  assign ts_next = ts_reg + 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_reg <= '0;
    end else begin
      ts_reg <= ts_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        time_mem[i] <= '0;
      end
    end else if (push) begin
      time_mem[wr_ptr_reg] <= ts_next;
    end
  end

  assign eventTime = time_mem[rd_ptr_reg];
`else
  assign eventTime = '0;
`endif

  // ------------------------------------------------------------------
  // Event pulse and saturating counters
  // ------------------------------------------------------------------
  logic                   ecc_status_reg;
  logic [COUNT_WIDTH-1:0] event_count_reg;
  logic [COUNT_WIDTH-1:0] dropped_count_reg;
  logic [SUM_W-1:0]       dropped_sum;
  logic [COUNT_WIDTH-1:0] dropped_next;

  assign dropped_sum  = {{POP_W{1'b0}}, dropped_count_reg}
                      + {{COUNT_WIDTH{1'b0}}, merged_count};
  // Any carry above the counter width means the count has run past all-ones.
  assign dropped_next = (|dropped_sum[SUM_W-1:COUNT_WIDTH]) ? '1
                                                             : dropped_sum[COUNT_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ecc_status_reg    <= 1'b0;
      event_count_reg   <= '0;
      dropped_count_reg <= '0;
    end else begin
      ecc_status_reg <= push;
      if (push && (event_count_reg != '1)) begin
        event_count_reg <= event_count_reg + COUNT_WIDTH'(1);
      end
      dropped_count_reg <= dropped_next;
    end
  end

  assign eccStatus    = ecc_status_reg;
  assign eventCount   = event_count_reg;
  assign droppedCount = dropped_count_reg;

endmodule

// File: tb/tb_ecc_error_collector.sv
// Self-checking bench for ecc_error_collector.
// A reference model tracks pending requests as a bit set, FIFO occupancy as
// an integer and expected records in a queue. A monitor on the falling edge
// compares every popped record and the per-cycle status outputs.
module tb_ecc_error_collector;

  localparam int NS    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NS-1:0] ecc_in = '0;
  logic          ready = 1'b0;

  logic          ecc_status;
  logic          ev_valid;
  logic [5:0]    ev_source;
  logic [31:0]   ev_time;
  logic [CW-1:0] ev_count;
  logic [CW-1:0] drop_count;

  ecc_error_collector #(
    .NUM_SOURCES(NS),
    .FIFO_DEPTH (DEPTH),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .eccStatusIn (ecc_in),
    .eccStatus   (ecc_status),
    .eventValid  (ev_valid),
    .eventReady  (ready),
    .eventSource (ev_source),
    .eventTime   (ev_time),
    .eventCount  (ev_count),
    .droppedCount(drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ------------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------------
  typedef struct packed {
    logic [5:0]  src;
    logic [31:0] tm;
  } rec_t;

  rec_t          sb_q[$];
  logic [NS-1:0] m_in1 = '0;      // last captured input sample
  logic [NS-1:0] m_in0 = '0;      // sample before that
  logic [NS-1:0] m_pend = '0;     // banks waiting for a FIFO slot
  int            m_occ = 0;       // records the FIFO should hold
  logic [31:0]   m_ts = '0;       // edges since reset
  int            m_evcnt = 0;
  int            m_drop = 0;
  logic          m_push_last = 1'b0;

  always @(posedge clk or posedge rst) begin
    logic [NS-1:0] rise_v;
    logic [NS-1:0] clr_v;
    int            idx_v;
    bit            pop_v;
    bit            push_v;
    rec_t          r_v;
    if (rst) begin
      m_in1       <= '0;
      m_in0       <= '0;
      m_pend      <= '0;
      m_occ       <= 0;
      m_ts        <= '0;
      m_evcnt     <= 0;
      m_drop      <= 0;
      m_push_last <= 1'b0;
      sb_q.delete();
    end else begin
      rise_v = m_in1 & ~m_in0;
      pop_v  = (m_occ > 0) && ready;
      push_v = (m_pend != '0) && ((m_occ < DEPTH) || pop_v);
      idx_v  = 0;
      for (int i = NS - 1; i >= 0; i--) if (m_pend[i]) idx_v = i;
      clr_v = '0;
      if (push_v) begin
        clr_v[idx_v] = 1'b1;
        r_v.src = 6'(idx_v);
`ifdef ECC_ERROR_TIMESTAMP_EN
        r_v.tm = m_ts + 32'd1;
`else
        r_v.tm = 32'd0;
`endif
        sb_q.push_back(r_v);
        m_evcnt <= (m_evcnt + 1 > CMAX) ? CMAX : m_evcnt + 1;
      end
      m_drop <= (m_drop + $countones(rise_v & m_pend & ~clr_v) > CMAX) ? CMAX
              : m_drop + $countones(rise_v & m_pend & ~clr_v);
      m_pend      <= (m_pend & ~clr_v) | rise_v;
      m_occ       <= m_occ + int'(push_v) - int'(pop_v);
      m_push_last <= push_v;
      m_ts        <= m_ts + 32'd1;
      m_in0       <= m_in1;
      m_in1       <= ecc_in;
    end
  end

  // ------------------------------------------------------------------
  // Monitor: per-cycle status and popped records
  // ------------------------------------------------------------------
  always @(negedge clk) begin
    rec_t r;
    if (!rst) begin
      chk("eventValid", longint'(ev_valid), longint'(m_occ != 0));
      chk("eccStatus", longint'(ecc_status), longint'(m_push_last));
      chk("eventCount", longint'(ev_count), longint'(m_evcnt));
      chk("droppedCount", longint'(drop_count), longint'(m_drop));
      if (ev_valid && ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL pop_unexpected: got record src=%0d, expected no record", ev_source);
        end else begin
          r = sb_q.pop_front();
          $display("pop src=%0d time=%0d (expected src=%0d time=%0d)",
                   ev_source, ev_time, r.src, r.tm);
          chk("eventSource", longint'(ev_source), longint'(r.src));
          chk("eventTime", longint'(ev_time), longint'(r.tm));
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 ns after an edge with reset released, so the next
  // rising edge is edge 1 of the new run.
  task automatic do_reset();
    ecc_in = '0;
    rst    = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  longint exp_time;

  initial begin
`ifdef ECC_ERROR_TIMESTAMP_EN
    exp_time = 12;
`else
    exp_time = 0;
`endif
    tick(1);
    chk("reset_eventValid", longint'(ev_valid), 0);
    chk("reset_eccStatus", longint'(ecc_status), 0);
    chk("reset_eventSource", longint'(ev_source), 0);
    chk("reset_eventTime", longint'(ev_time), 0);
    chk("reset_eventCount", longint'(ev_count), 0);
    chk("reset_droppedCount", longint'(drop_count), 0);

    // Single source: bit 5 captured at edge 10.
    do_reset();
    ready = 1'b1;
    tick(9);
    ecc_in[5] = 1'b1;
    tick(1);
    ecc_in[5] = 1'b0;
    tick(1);
    chk("single_no_early_pulse", longint'(ecc_status), 0);
    tick(1);
    chk("single_pulse", longint'(ecc_status), 1);
    chk("single_valid", longint'(ev_valid), 1);
    chk("single_source", longint'(ev_source), 5);
    chk("single_time", longint'(ev_time), exp_time);
    chk("single_count", longint'(ev_count), 1);

    // Simultaneous sources 3, 7, 20.
    do_reset();
    ready = 1'b1;
    ecc_in = (NS'(1) << 3) | (NS'(1) << 7) | (NS'(1) << 20);
    tick(1);
    ecc_in = '0;
    tick(2);
    chk("simul_first_source", longint'(ev_source), 3);
    tick(6);
    chk("simul_count", longint'(ev_count), 3);
    chk("simul_drained", longint'(ev_valid), 0);

    // Backpressure: nine sources into an eight-deep FIFO.
    do_reset();
    ready = 1'b0;
    ecc_in = NS'(9'h1FF);
    tick(1);
    ecc_in = '0;
    tick(12);
    chk("bp_count_full", longint'(ev_count), 8);
    chk("bp_head_stable", longint'(ev_source), 0);
    ecc_in[8] = 1'b1;
    tick(1);
    ecc_in[8] = 1'b0;
    tick(3);
    chk("bp_merge_dropped", longint'(drop_count), 1);
    chk("bp_count_held", longint'(ev_count), 8);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    chk("bp_push_on_pop", longint'(ecc_status), 1);
    chk("bp_count_ninth", longint'(ev_count), 9);
    chk("bp_next_head", longint'(ev_source), 1);
    ready = 1'b1;
    tick(12);
    chk("bp_drained", longint'(ev_valid), 0);

    // Saturation: 20 events into a 4-bit counter.
    do_reset();
    ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ecc_in = NS'(1) << i;
      tick(1);
    end
    ecc_in = '0;
    tick(6);
    chk("sat_event_count", longint'(ev_count), 15);
    chk("sat_no_drops", longint'(drop_count), 0);

    // Held level: one event only.
    do_reset();
    ready = 1'b1;
    ecc_in[0] = 1'b1;
    tick(50);
    ecc_in[0] = 1'b0;
    tick(5);
    chk("held_one_event", longint'(ev_count), 1);

    // Asynchronous reset with three records queued.
    do_reset();
    ready = 1'b0;
    ecc_in = NS'(32'hE);
    tick(1);
    ecc_in = '0;
    tick(4);
    chk("arst_pre_pulse", longint'(ecc_status), 1);
    chk("arst_pre_count", longint'(ev_count), 3);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", longint'(ev_valid), 0);
    chk("arst_eccStatus", longint'(ecc_status), 0);
    chk("arst_eventCount", longint'(ev_count), 0);
    chk("arst_dropped", longint'(drop_count), 0);
    tick(1);
    rst = 1'b0;
    ready = 1'b1;
    tick(10);
    chk("arst_no_stale", longint'(ev_valid), 0);
    chk("arst_count_after", longint'(ev_count), 0);

    // Randomized traffic with varying backpressure.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ((c / 100) % 3 == 1) ready = 1'b0;
      else ready = ($urandom_range(0, 3) != 0);
      ecc_in = ecc_in ^ NS'($urandom & $urandom & $urandom);
      tick(1);
    end
    ecc_in = '0;
    ready  = 1'b1;
    tick(80);
    chk("rand_drained", longint'(ev_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
